// File: rtl/mic_frame_if.sv
// mic_frame_if: TDM sample stream in, parallel frame out, both valid/ready
interface mic_frame_if #(
  parameter int NUM_CH = 16,
  parameter int IN_W   = 19
);
  logic [IN_W-1:0]        s_data;
  logic                   s_first;
  logic                   s_valid;
  logic                   s_ready;
  logic [NUM_CH*IN_W-1:0] m_data;
  logic                   m_valid;
  logic                   m_ready;
  modport slave (input s_data, s_first, s_valid, m_ready, output s_ready, m_data, m_valid);
  modport master (output s_data, s_first, s_valid, m_ready, input s_ready, m_data, m_valid);
endinterface

// File: rtl/mic_frame_assembler.sv
// mic_frame_assembler: gathers NUM_CH TDM samples into one parallel frame with one frame of output buffering
module mic_frame_assembler #(
  parameter int NUM_CH = 16,
  parameter int IN_W   = 19,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  mic_frame_if.slave       s,
  output logic             sync_err,
  output logic [CNT_W-1:0] frame_cnt
);
  localparam int IDX_W = $clog2(NUM_CH);
  typedef enum logic [1:0] {HUNT, FILL, HOLD} state_t;
  state_t state;
  logic [IDX_W-1:0] idx;
  logic [NUM_CH-1:0][IN_W-1:0] fbuf;
  logic acc, consume;
  assign s.s_ready = state != HOLD;
  assign acc = s.s_valid && s.s_ready;
  assign consume = s.m_valid && s.m_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= HUNT;
      idx       <= '0;
      fbuf      <= '0;
      s.m_data  <= '0;
      s.m_valid <= 1'b0;
      sync_err  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      sync_err <= 1'b0;
      if (consume) s.m_valid <= 1'b0;
      case (state)
        HUNT: if (acc && s.s_first) begin
          fbuf[0] <= s.s_data;
          idx     <= IDX_W'(1);
          state   <= FILL;
        end
        FILL: if (acc) begin
          if (s.s_first) begin
            fbuf[0]  <= s.s_data;
            idx      <= IDX_W'(1);
            sync_err <= idx != '0;
          end else if (idx == '0) begin
            sync_err <= 1'b1;
            state    <= HUNT;
          end else begin
            fbuf[idx] <= s.s_data;
            idx       <= idx + IDX_W'(1);
            // last slot: bypass the fill buffer straight into the output if it is free
            if (&idx) begin
              if (!s.m_valid || s.m_ready) begin
                s.m_data  <= {s.s_data, fbuf[NUM_CH-2:0]};
                s.m_valid <= 1'b1;
                frame_cnt <= frame_cnt + CNT_W'(1);
              end else state <= HOLD;
            end
          end
        end
        HOLD: if (consume) begin
          s.m_data  <= fbuf;
          s.m_valid <= 1'b1;
          frame_cnt <= frame_cnt + CNT_W'(1);
          state     <= FILL;
        end
        default: state <= HUNT;
      endcase
    end
endmodule

// File: tb/tb_mic_frame_assembler.sv
// tb_mic_frame_assembler: queue-based frame model checked every cycle plus hand-computed literal checks
module tb_mic_frame_assembler;
  localparam int NUM_CH = 16;
  localparam int IN_W   = 19;
  localparam int CNT_W  = 16;
  localparam int NW     = NUM_CH * IN_W;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sync_err;
  logic [CNT_W-1:0] frame_cnt;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  mic_frame_if #(.NUM_CH(NUM_CH), .IN_W(IN_W)) bus ();
  mic_frame_assembler #(.NUM_CH(NUM_CH), .IN_W(IN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .s(bus.slave), .sync_err(sync_err), .frame_cnt(frame_cnt)
  );
  always #5 clk = ~clk;

  logic [IN_W-1:0] col[$];
  bit synced = 0, mv = 0, held = 0, err = 0;
  logic [NW-1:0] out_f = '0, held_f = '0, frame;
  logic [CNT_W-1:0] cnt = '0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col.delete();
      synced = 0; mv = 0; held = 0; err = 0; cnt = '0; out_f = '0;
    end else begin
      err = 0;
      if (held) begin
        if (mv && bus.m_ready) begin
          out_f = held_f; cnt = cnt + CNT_W'(1); held = 0;
        end
      end else begin
        if (mv && bus.m_ready) mv = 0;
        if (bus.s_valid) begin
          if (bus.s_first) begin
            err = col.size() != 0;
            col.delete();
            col.push_back(bus.s_data);
            synced = 1;
          end else if (synced && col.size() == 0) begin
            err = 1; synced = 0;
          end else if (synced) begin
            col.push_back(bus.s_data);
            if (col.size() == NUM_CH) begin
              for (int k = 0; k < NUM_CH; k++) frame[k*IN_W +: IN_W] = col[k];
              col.delete();
              if (!mv) begin
                out_f = frame; mv = 1; cnt = cnt + CNT_W'(1);
              end else begin
                held_f = frame; held = 1;
              end
            end
          end
        end
      end
    end

  task automatic chk(input string n, input logic [NW-1:0] act, input logic [NW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    if (sync_err) pulses++;
    chk("m_valid", NW'(bus.m_valid), NW'(mv));
    chk("s_ready", NW'(bus.s_ready), NW'(!held));
    chk("sync_err", NW'(sync_err), NW'(err));
    chk("frame_cnt", NW'(frame_cnt), NW'(cnt));
    if (mv) chk("m_data", bus.m_data, out_f);
  end

  function automatic logic [IN_W-1:0] fld(input int k);
    return bus.m_data[k*IN_W +: IN_W];
  endfunction

  task automatic send(input logic [IN_W-1:0] d, input bit f);
    bit a;
    bus.s_valid = 1'b1; bus.s_data = d; bus.s_first = f;
    for (int i = 0; ; i++) begin
      a = bus.s_ready;
      @(posedge clk); #1;
      if (a) break;
      if (i == 200) begin
        checks++; errors++;
        $display("FAIL send_timeout sample %0h not accepted within 200 cycles", d);
        break;
      end
    end
    bus.s_valid = 1'b0; bus.s_first = 1'b0;
  endtask

  task automatic send_frame(input int base);
    for (int k = 0; k < NUM_CH; k++) send(IN_W'(base + k), k == 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.s_valid = 1'b0; bus.s_first = 1'b0; bus.s_data = '0; bus.m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", NW'(bus.m_valid), NW'(0));
    chk("rst_s_ready", NW'(bus.s_ready), NW'(1));
    chk("rst_frame_cnt", NW'(frame_cnt), NW'(0));
    chk("rst_sync_err", NW'(sync_err), NW'(0));
    rst_n = 1'b1;
    send_frame(1);
    chk("f1_m_valid", NW'(bus.m_valid), NW'(1));
    chk("f1_ch0", NW'(fld(0)), NW'(1));
    chk("f1_ch15", NW'(fld(15)), NW'(16));
    chk("f1_cnt", NW'(frame_cnt), NW'(1));
    for (int k = 0; k < NUM_CH; k++)
      send(k == 3 ? 19'h7FFFF : k == 4 ? 19'h40000 : IN_W'(k), k == 0);
    chk("max_ch3", NW'(fld(3)), NW'(32'h7FFFF));
    chk("min_ch4", NW'(fld(4)), NW'(32'h40000));
    chk("f2_cnt", NW'(frame_cnt), NW'(2));
    chk("no_err_yet", NW'(pulses), NW'(0));
    do_reset();
    for (int k = 0; k < 5; k++) send(IN_W'(50 + k), 1'b0);
    send_frame(100);
    chk("hunt_ch0", NW'(fld(0)), NW'(100));
    chk("hunt_ch15", NW'(fld(15)), NW'(115));
    chk("hunt_cnt", NW'(frame_cnt), NW'(1));
    chk("hunt_no_err", NW'(pulses), NW'(0));
    for (int k = 0; k < 7; k++) send(IN_W'(200 + k), k == 0);
    send_frame(300);
    chk("resync_pulses", NW'(pulses), NW'(1));
    chk("resync_ch0", NW'(fld(0)), NW'(300));
    chk("resync_ch15", NW'(fld(15)), NW'(315));
    do_reset();
    bus.m_ready = 1'b0;
    fork
      begin
        send_frame(400); send_frame(500); send_frame(600);
      end
      begin
        repeat (40) begin @(posedge clk); #1; end
        chk("hold_s_ready", NW'(bus.s_ready), NW'(0));
        chk("hold_ch0_A", NW'(fld(0)), NW'(400));
        chk("hold_cnt", NW'(frame_cnt), NW'(1));
        bus.m_ready = 1'b1;
        @(posedge clk); #1;
        chk("rel_ch0_B", NW'(fld(0)), NW'(500));
        chk("rel_ch15_B", NW'(fld(15)), NW'(515));
        chk("rel_cnt", NW'(frame_cnt), NW'(2));
      end
    join
    chk("C_ch0", NW'(fld(0)), NW'(600));
    chk("C_ch15", NW'(fld(15)), NW'(615));
    chk("C_cnt", NW'(frame_cnt), NW'(3));
    repeat (2) @(posedge clk);
    #1;
    bus.m_ready = 1'b0;
    send_frame(700);
    for (int k = 0; k < 9; k++) send(IN_W'(800 + k), k == 0);
    chk("pre_rst_m_valid", NW'(bus.m_valid), NW'(1));
    rst_n = 1'b0;
    #1;
    chk("arst_m_valid", NW'(bus.m_valid), NW'(0));
    chk("arst_m_data", bus.m_data, NW'(0));
    chk("arst_cnt", NW'(frame_cnt), NW'(0));
    chk("arst_s_ready", NW'(bus.s_ready), NW'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.m_ready = 1'b1;
    send_frame(900);
    chk("post_rst_ch0", NW'(fld(0)), NW'(900));
    chk("post_rst_ch15", NW'(fld(15)), NW'(915));
    chk("post_rst_cnt", NW'(frame_cnt), NW'(1));
    repeat (3) @(posedge clk);
    #1;
    chk("total_pulses", NW'(pulses), NW'(1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
